// File: rtl/single_port_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : single_port_mem_if
// Description : Request/response bundle for the single-port memory.
//               master : drives wr_rd, valid, wdata, addr; observes rdata, ready
//               slave  : observes the request; drives rdata, ready
// Revision    : 1.0 - initial release
// ============================================================================
interface single_port_mem_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_rd;   // 1 = write, 0 = read
    logic                  valid;   // request strobe
    logic [DATA_WIDTH-1:0] wdata;   // write data
    logic [ADDR_WIDTH-1:0] addr;    // word address
    logic [DATA_WIDTH-1:0] rdata;   // registered read data
    logic                  ready;   // registered accept indication

    modport master (
        output wr_rd, valid, wdata, addr,
        input  rdata, ready
    );

    modport slave (
        input  wr_rd, valid, wdata, addr,
        output rdata, ready
    );
endinterface
`default_nettype wire

// File: rtl/single_port_mem.sv
`default_nettype none
// ============================================================================
// Module      : single_port_mem
// Description : Single-port synchronous memory, one transfer per cycle.
//               Writes land at the accepting edge; reads return data on rdata
//               one cycle after the request. Reset clears every word.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - single_port_mem_if slave (wr_rd, valid, wdata, addr,
//                      rdata, ready)
// Revision    : 1.0 - initial release
// ============================================================================
module single_port_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  wire                clk,
    input  wire                rst,
    single_port_mem_if.slave   bus
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic                  ready_q;
    logic                  ready_d;
    logic                  wr_en_d;

    // A transfer needs the previously registered ready, so a request in the
    // first cycle after reset (ready still 0) is dropped.
    always_comb begin
        ready_d = 1'b1;
        rdata_d = rdata_q;
        wr_en_d = 1'b0;
        if (bus.valid && ready_q) begin
            if (bus.wr_rd) begin
                wr_en_d = 1'b1;
            end else begin
                rdata_d = mem_q[bus.addr];
            end
        end
    end

    // Reset wins over any request on the same edge and wipes the whole array.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            if (wr_en_d) begin
                mem_q[bus.addr] <= bus.wdata;
            end
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_single_port_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_single_port_mem
// Description : Self-checking bench for single_port_mem: directed vector
//               table, back-to-back sweep, then random traffic compared with
//               a behavioural memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_single_port_mem;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NW = 16;

    logic clk;
    logic rst;

    single_port_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    single_port_mem #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (NW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic          rst;
        logic          valid;
        logic          wr_rd;
        logic [DW-1:0] wdata;
        logic [AW-1:0] addr;
        logic [DW-1:0] exp_rdata;
        logic          exp_ready;
        string         name;
    } vec_t;

    vec_t vecs[$];

    int n_tests;
    int n_fail;

    // Reference model: plain array of words plus the visible outputs.
    logic [DW-1:0] m_mem [NW];
    logic [DW-1:0] m_rdata;
    logic          m_ready;

    task automatic addv(input logic r, input logic v, input logic w,
                        input logic [DW-1:0] wd, input logic [AW-1:0] a,
                        input logic [DW-1:0] er, input logic erdy,
                        input string nm);
        vec_t t;
        t.rst = r; t.valid = v; t.wr_rd = w; t.wdata = wd; t.addr = a;
        t.exp_rdata = er; t.exp_ready = erdy; t.name = nm;
        vecs.push_back(t);
    endtask

    task automatic check(input string nm, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge pass, advance the model,
    // and leave time 1 ns past the edge for sampling.
    task automatic cycle(input logic r, input logic v, input logic w,
                         input logic [DW-1:0] wd, input logic [AW-1:0] a);
        rst       = r;
        bus.valid = v;
        bus.wr_rd = w;
        bus.wdata = wd;
        bus.addr  = a;
        @(posedge clk);
        if (r) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_rdata = '0;
            m_ready = 1'b0;
        end else begin
            if (v && m_ready) begin
                if (w) m_mem[a] = wd;
                else   m_rdata = m_mem[a];
            end
            m_ready = 1'b1;
        end
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_rdata = '0;
        m_ready = 1'b0;
        foreach (m_mem[i]) m_mem[i] = '0;
        rst = 1'b1; bus.valid = 1'b0; bus.wr_rd = 1'b0;
        bus.wdata = '0; bus.addr = '0;

        // ---------------- directed table ----------------
        //    rst   valid wr    wdata  addr   exp_rd exp_rdy
        addv(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0, "reset");
        addv(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b1, "ready_up");
        addv(1'b0, 1'b1, 1'b1, 8'hA5, 4'h3, 8'h00, 1'b1, "wr_a5");
        addv(1'b0, 1'b1, 1'b0, 8'h00, 4'h3, 8'hA5, 1'b1, "rd_a5");
        addv(1'b0, 1'b1, 1'b1, 8'h3C, 4'h7, 8'hA5, 1'b1, "wr_3c");
        addv(1'b0, 1'b1, 1'b0, 8'h00, 4'h7, 8'h3C, 1'b1, "rd_3c");
        addv(1'b0, 1'b0, 1'b0, 8'h99, 4'h1, 8'h3C, 1'b1, "hold1");
        addv(1'b0, 1'b0, 1'b1, 8'h98, 4'h9, 8'h3C, 1'b1, "hold2");
        addv(1'b0, 1'b0, 1'b0, 8'h97, 4'h7, 8'h3C, 1'b1, "hold3");
        addv(1'b0, 1'b1, 1'b1, 8'hFF, 4'h5, 8'h3C, 1'b1, "wr_ff");
        addv(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0, "rst_mid");
        addv(1'b0, 1'b1, 1'b1, 8'h55, 4'h6, 8'h00, 1'b1, "wr_not_ready");
        addv(1'b0, 1'b1, 1'b0, 8'h00, 4'h5, 8'h00, 1'b1, "rd_after_rst");
        addv(1'b1, 1'b1, 1'b1, 8'h77, 4'h2, 8'h00, 1'b0, "wr_during_rst");
        addv(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b1, "ready_again");
        addv(1'b0, 1'b1, 1'b0, 8'h00, 4'h2, 8'h00, 1'b1, "rd_discarded");
        addv(1'b0, 1'b1, 1'b1, 8'h11, 4'h2, 8'h00, 1'b1, "wr_11");
        addv(1'b0, 1'b1, 1'b0, 8'h00, 4'h6, 8'h00, 1'b1, "rd_ignored_wr");
        addv(1'b0, 1'b1, 1'b0, 8'h00, 4'h2, 8'h11, 1'b1, "rd_11");

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst, vecs[i].valid, vecs[i].wr_rd,
                  vecs[i].wdata, vecs[i].addr);
            check({vecs[i].name, "_rdata"}, bus.rdata, vecs[i].exp_rdata);
            check({vecs[i].name, "_ready"}, {7'd0, bus.ready},
                  {7'd0, vecs[i].exp_ready});
        end

        // ---------------- back-to-back sweep ----------------
        for (int i = 0; i < NW; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 8'h10 + 8'(i), 4'(i));
        end
        for (int i = 0; i < NW; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h00, 4'(i));
            check($sformatf("sweep_rd%0d", i), bus.rdata, 8'h10 + 8'(i));
        end

        // ---------------- randomized traffic vs model ----------------
        for (int n = 0; n < 400; n++) begin
            logic r;
            r = ($urandom_range(0, 29) == 0);
            cycle(r, 1'($urandom), 1'($urandom), 8'($urandom), 4'($urandom));
            check($sformatf("rand%0d_rdata", n), bus.rdata, m_rdata);
            check($sformatf("rand%0d_ready", n), {7'd0, bus.ready},
                  {7'd0, m_ready});
        end

        // Final readback of every word against the model.
        for (int i = 0; i < NW; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h00, 4'(i));
            check($sformatf("final_rd%0d", i), bus.rdata, m_mem[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/single_port_mem.md
SINGLE_PORT_MEM -- requirements
Module: single_port_mem

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 8, the width in bits of each memory word.
REQ-002 The block SHALL expose parameter ADDR_WIDTH, default 4, the width in bits of the address bus.
REQ-003 The block SHALL expose parameter DEPTH, default 16 (2**ADDR_WIDTH), the number of words.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 wr_rd  input  1  operation select: 1 = write, 0 = read; sampled only when valid=1.
REQ-007 valid  input  1  request strobe; a transfer occurs on a rising edge where valid=1 and ready=1.
REQ-008 wdata  input  DATA_WIDTH  write data; sampled on write transfers.
REQ-009 addr  input  ADDR_WIDTH  word address; sampled on every transfer.
REQ-010 rdata  output  DATA_WIDTH  registered read data.
REQ-011 ready  output  1  registered; 1 = block accepts a request this cycle.

Function
REQ-012 Storage SHALL be DEPTH words of DATA_WIDTH bits, one port, one transfer per cycle.
REQ-013 Write transfer (valid=1, ready=1, wr_rd=1) SHALL store wdata into mem[addr] at that rising edge; rdata SHALL be unchanged.
REQ-014 Read transfer (valid=1, ready=1, wr_rd=0) SHALL load mem[addr] into rdata at that rising edge (value visible one cycle after request, latency 1).
REQ-015 Read of an address written in an earlier cycle SHALL return the written data; no same-cycle read/write conflict exists (single port).
REQ-016 rdata SHALL hold its last value on cycles without a read transfer.
REQ-017 With valid=0, memory and rdata SHALL be unchanged; wr_rd, wdata, addr are don't-care.
REQ-018 ready SHALL be 0 while rst=1 and SHALL be 1 from the first rising edge after rst deasserts; it SHALL stay 1 (no back-pressure) until the next reset.
REQ-019 Requests with valid=1 while ready=0 SHALL be ignored (no write, rdata unchanged).
REQ-020 Back-to-back transfers on consecutive cycles SHALL all complete; consecutive reads SHALL update rdata every cycle.
REQ-021 Addresses SHALL be used in full; every ADDR_WIDTH value maps to a distinct word, no wrap/alias logic beyond the bus width.
REQ-022 Memory contents SHALL be 0 after reset, not X.

Reset
REQ-023 On a rising edge with rst=1: all memory words <= 0, rdata <= 0, ready <= 0.
REQ-024 rst SHALL take priority over any simultaneous valid request; that request SHALL be discarded.
REQ-025 Reset asserted mid-sequence SHALL erase all prior writes; reads after reset SHALL return 0 until rewritten.

Verification
REQ-026 rst=1 for one edge, then 0 -> ready=0 during reset, ready=1 on next edge; rdata=0.
REQ-027 Write 0xA5 to addr 3, next cycle read addr 3 -> rdata=0xA5 one cycle after the read request.
REQ-028 Write addr 0..15 with data=addr+0x10 back-to-back, then read 0..15 back-to-back -> rdata sequence 0x10..0x1F, one per cycle.
REQ-029 Read addr 7 (0x3C previously written), then 3 idle cycles with valid=0 and addr changing -> rdata holds 0x3C.
REQ-030 Write 0xFF to addr 5, assert rst one cycle, read addr 5 -> rdata=0x00.
REQ-031 valid=1, wr_rd=1, wdata=0x77, addr 2 in same cycle as rst=1, then read addr 2 -> rdata=0x00.
